// File: rtl/shift_ex_stage_pkg.sv
// ---------------------------------------------------------------------------
// shift_ex_stage_pkg
// Shared definitions for the execute-stage shift unit: the shift op
// encodings, the datapath width and the default register-specifier width.
// ---------------------------------------------------------------------------
package shift_ex_stage_pkg;

  localparam int DATA_W       = 16;
  localparam int AMT_W        = 4;
  localparam int REG_BITS_DEF = 3;

  typedef enum logic [1:0] {
    OP_SHL = 2'b00,
    OP_SRL = 2'b01,
    OP_ROL = 2'b10,
    OP_ROR = 2'b11
  } shift_op_e;

endpackage

// File: rtl/shifter_16b.sv
// ---------------------------------------------------------------------------
// shifter_16b
// Combinational 16-bit barrel shifter core.
// Ports:
//   op     - shift operation (shl, srl zero fill, rol, ror)
//   data   - operand to shift
//   amt    - shift amount 0..15 (0 passes the operand through)
//   result - shifted operand
// ---------------------------------------------------------------------------
module shifter_16b
  import shift_ex_stage_pkg::*;
(
  input  shift_op_e         op,
  input  logic [DATA_W-1:0] data,
  input  logic [AMT_W-1:0]  amt,
  output logic [DATA_W-1:0] result
);

  logic [2*DATA_W-1:0] doubled;
  logic [2*DATA_W-1:0] rol_full;
  logic [2*DATA_W-1:0] ror_full;

  // Rotates are done by shifting the operand concatenated with itself:
  // the bits pushed out of one copy are refilled from the other copy.
  always_comb begin
    doubled  = {data, data};
    rol_full = doubled << amt;
    ror_full = doubled >> amt;
    result   = data;
    case (op)
      OP_SHL:  result = data << amt;
      OP_SRL:  result = data >> amt;
      OP_ROL:  result = rol_full[2*DATA_W-1:DATA_W];
      OP_ROR:  result = ror_full[DATA_W-1:0];
      default: result = data;
    endcase
  end

endmodule

// File: rtl/shift_ex_stage.sv
// ---------------------------------------------------------------------------
// shift_ex_stage
// Execute-stage shift unit. Accepts shift ops over a valid/ready handshake,
// optionally bypasses the previous result into the data operand, shifts it
// with shifter_16b and holds results in a main register plus a skid
// register feeding EX/MEM.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   flush             - synchronous pipeline flush
//   in_valid/in_ready - upstream handshake (in_ready is registered)
//   in_op, in_data    - operation and operand (register in_src)
//   in_src_use        - operand comes from a register (bypass eligible)
//   in_amt_sel        - 0: amount from in_amt_reg[3:0], 1: from in_imm
//   in_dst, in_wr_en  - destination register and its write enable
//   out_valid/ready   - downstream handshake
//   out_data, out_dst, out_wr_en - registered result to EX/MEM
// ---------------------------------------------------------------------------
module shift_ex_stage
  import shift_ex_stage_pkg::*;
#(
  parameter int REG_BITS  = REG_BITS_DEF,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_op,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [REG_BITS-1:0] in_src,
  input  logic                in_src_use,
  input  logic                in_amt_sel,
  input  logic [DATA_W-1:0]   in_amt_reg,
  input  logic [AMT_W-1:0]    in_imm,
  input  logic [REG_BITS-1:0] in_dst,
  input  logic                in_wr_en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [REG_BITS-1:0] out_dst,
  output logic                out_wr_en
);

  logic                accept;
  logic                out_fire;
  logic                bypass_hit;
  logic [AMT_W-1:0]    amt;
  logic [DATA_W-1:0]   operand;
  logic [DATA_W-1:0]   result;
  logic                unused_amt_hi;

  logic                skid_valid;
  logic [DATA_W-1:0]   skid_data;
  logic [REG_BITS-1:0] skid_dst;
  logic                skid_wr_en;

  logic                last_valid;
  logic [DATA_W-1:0]   last_data;
  logic [REG_BITS-1:0] last_dst;
  logic                last_wr_en;

  // skid_valid is a flop, so in_ready never depends on out_ready this cycle.
  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready & ~flush;
  assign out_fire = out_valid & out_ready;

  // Only the low nibble of Rt is a shift amount.
  assign unused_amt_hi = ^in_amt_reg[DATA_W-1:AMT_W];
  assign amt           = in_amt_sel ? in_imm : in_amt_reg[AMT_W-1:0];

  // A result that does not write a register can never be a bypass source.
  assign bypass_hit = BYPASS_EN && in_src_use && last_valid && last_wr_en &&
                      (in_src == last_dst);
  assign operand    = bypass_hit ? last_data : in_data;

  shifter_16b u_shifter (
    .op     (shift_op_e'(in_op)),
    .data   (operand),
    .amt    (amt),
    .result (result)
  );

  // Main/skid output registers. A new op goes to main when main is empty or
  // draining with nothing behind it; otherwise it parks in skid. Accepting
  // while skid is full is impossible because in_ready is low then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_dst    <= '0;
      out_wr_en  <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_dst   <= '0;
      skid_wr_en <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_fire) begin
      if (skid_valid) begin
        out_data   <= skid_data;
        out_dst    <= skid_dst;
        out_wr_en  <= skid_wr_en;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= accept;
        if (accept) begin
          out_data  <= result;
          out_dst   <= in_dst;
          out_wr_en <= in_wr_en;
        end
      end
    end else if (accept) begin
      if (!out_valid) begin
        out_valid <= 1'b1;
        out_data  <= result;
        out_dst   <= in_dst;
        out_wr_en <= in_wr_en;
      end else begin
        skid_valid <= 1'b1;
        skid_data  <= result;
        skid_dst   <= in_dst;
        skid_wr_en <= in_wr_en;
      end
    end
  end

  // Bypass source tracks the most recently accepted op, even if it is still
  // sitting in main or skid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_valid <= 1'b0;
      last_data  <= '0;
      last_dst   <= '0;
      last_wr_en <= 1'b0;
    end else if (flush) begin
      last_valid <= 1'b0;
    end else if (accept) begin
      last_valid <= 1'b1;
      last_data  <= result;
      last_dst   <= in_dst;
      last_wr_en <= in_wr_en;
    end
  end

endmodule
